// File: rtl/cordic_sign_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_sign_seq
//  Purpose  : CORDIC direction-sequence generator. Captures a target angle
//             and walks the arctangent table one iteration per clock. Each
//             cycle it emits the micro-rotation direction. At completion it
//             presents the packed direction vector and the residual angle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ANGLE_W  angle width, signed degrees in Q(ANGLE_W-8).8 (16..24)
//    ITERS    number of CORDIC iterations (1..16)
//  Ports
//    Clk        in   clock, rising edge
//    reset      in   asynchronous, active-low reset
//    start      in   begin operation (sampled only when idle)
//    clear      in   synchronous abort to idle, wins over start
//    theta      in   target angle, captured on accepted start
//    busy       out  operation in progress (through the done cycle)
//    dir_valid  out  dir / iter_idx valid this cycle
//    dir        out  1 = positive rotation (residual >= 0)
//    iter_idx   out  iteration number of the current dir
//    dirs       out  bit i = direction of iteration i, held after done
//    residual   out  residual angle, final at done and held
//    quad       out  pre-rotation code (00 none, 01 -90 applied, 11 +90)
//    done       out  one-cycle completion pulse
//  Build option
//    SIGN_SEQ_QUADRANT_EN  adds a one-cycle +/-90 degree pre-rotation (PRE)
// ============================================================================
module cordic_sign_seq #(
    parameter int ANGLE_W = 16,
    parameter int ITERS   = 8
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               start,
    input  logic               clear,
    input  logic [ANGLE_W-1:0] theta,
    output logic               busy,
    output logic               dir_valid,
    output logic               dir,
    output logic [3:0]         iter_idx,
    output logic [ITERS-1:0]   dirs,
    output logic [ANGLE_W-1:0] residual,
    output logic [1:0]         quad,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] C_LAST = 4'(ITERS - 1);

    state_t r_state;

    // Arctangent of 2^-i in Q8.8 degrees.
    function automatic logic [15:0] atan_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_rom = 16'd11520;
            4'd1:    atan_rom = 16'd6801;
            4'd2:    atan_rom = 16'd3593;
            4'd3:    atan_rom = 16'd1824;
            4'd4:    atan_rom = 16'd916;
            4'd5:    atan_rom = 16'd458;
            4'd6:    atan_rom = 16'd229;
            4'd7:    atan_rom = 16'd115;
            4'd8:    atan_rom = 16'd57;
            4'd9:    atan_rom = 16'd29;
            4'd10:   atan_rom = 16'd14;
            4'd11:   atan_rom = 16'd7;
            4'd12:   atan_rom = 16'd4;
            4'd13:   atan_rom = 16'd2;
            4'd14:   atan_rom = 16'd1;
            default: atan_rom = 16'd0;
        endcase
    endfunction

    // The residual is kept in ANGLE_W bits: an ANGLE_W+1 bit add/subtract
    // truncated to ANGLE_W is bit-identical to ANGLE_W modular arithmetic.
    logic [ANGLE_W-1:0] w_atan;
    logic [ANGLE_W-1:0] w_step;
    logic [3:0]         w_idx_next;
    logic               w_dir_next;

    always_comb begin
        w_atan     = ANGLE_W'(atan_rom(iter_idx));
        // dir already equals ~residual[MSB] for the iteration on display.
        w_step     = dir ? (residual - w_atan) : (residual + w_atan);
        w_idx_next = iter_idx + 4'd1;
        w_dir_next = ~w_step[ANGLE_W-1];
    end

`ifdef SIGN_SEQ_QUADRANT_EN
    localparam logic [ANGLE_W-1:0] C_RIGHT = ANGLE_W'(23040);

    logic [ANGLE_W-1:0] w_pre;
    logic [1:0]         w_quad;

    always_comb begin
        w_pre  = residual;
        w_quad = 2'b00;
        if ($signed(residual) > $signed(C_RIGHT)) begin
            w_pre  = residual - C_RIGHT;
            w_quad = 2'b01;
        end else if ($signed(residual) < -$signed(C_RIGHT)) begin
            w_pre  = residual + C_RIGHT;
            w_quad = 2'b11;
        end
    end
`else
    assign quad = 2'b00;
`endif

    // Outputs are registered one step ahead: the dir of iteration i is
    // computed on the edge that enters iteration i, so dir / iter_idx /
    // dirs[i] and the pre-update residual are all shown in the same cycle.
    // dirs is not cleared on accept; each bit is overwritten as its
    // iteration is reached.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            dir_valid <= 1'b0;
            dir       <= 1'b0;
            iter_idx  <= 4'd0;
            dirs      <= '0;
            residual  <= '0;
            done      <= 1'b0;
`ifdef SIGN_SEQ_QUADRANT_EN
            quad      <= 2'b00;
`endif
        end else if (clear) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            dir_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        residual <= theta;
                        iter_idx <= 4'd0;
`ifdef SIGN_SEQ_QUADRANT_EN
                        r_state  <= S_PRE;
`else
                        r_state   <= S_ITER;
                        dir_valid <= 1'b1;
                        dir       <= ~theta[ANGLE_W-1];
                        dirs[0]   <= ~theta[ANGLE_W-1];
`endif
                    end
                end
`ifdef SIGN_SEQ_QUADRANT_EN
                S_PRE: begin
                    residual  <= w_pre;
                    quad      <= w_quad;
                    r_state   <= S_ITER;
                    dir_valid <= 1'b1;
                    dir       <= ~w_pre[ANGLE_W-1];
                    dirs[0]   <= ~w_pre[ANGLE_W-1];
                end
`endif
                S_ITER: begin
                    residual <= w_step;
                    if (iter_idx == C_LAST) begin
                        r_state   <= S_DONE;
                        dir_valid <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        iter_idx <= w_idx_next;
                        dir      <= w_dir_next;
                        for (int k = 1; k < ITERS; k++) begin
                            if (4'(k) == w_idx_next) begin
                                dirs[k] <= w_dir_next;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
